// File: rtl/stream_deserializer.sv
// Packs Ratio narrow beats (lane 0 first) into one registered wide word with
// a lane strobe; an in_last_i beat closes the word early.
module stream_deserializer #(
  parameter int DataWidth = 8,
  parameter int Ratio     = 4,
  parameter int CntWidth  = (Ratio > 1) ? $clog2(Ratio) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic [DataWidth-1:0]       in_data_i,
  input  logic                       in_last_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [DataWidth*Ratio-1:0] out_data_o,
  output logic [Ratio-1:0]           out_strb_o,
  output logic                       out_last_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int AsmWidth  = (Ratio > 1) ? (Ratio - 1) * DataWidth : DataWidth;
  localparam int WordWidth = DataWidth * Ratio;
  localparam logic [CntWidth-1:0] LastLane = CntWidth'(Ratio - 1);

  logic [CntWidth-1:0]  cnt_q;
  logic [AsmWidth-1:0]  asm_q;
  logic [AsmWidth-1:0]  asm_nxt;
  logic [WordWidth-1:0] out_data_q;
  logic [WordWidth-1:0] word_nxt;
  logic [Ratio-1:0]     out_strb_q;
  logic [Ratio-1:0]     strb_nxt;
  logic                 out_last_q;
  logic                 out_valid_q;
  logic                 accept;
  logic                 closing;

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;
  assign closing    = (cnt_q == LastLane) || in_last_i;

  // The buffer only holds lanes 0..Ratio-2; the final lane comes straight
  // from the closing beat, so the word is built from both sources here.
  always_comb begin
    word_nxt = '0;
    strb_nxt = '0;
    asm_nxt  = asm_q;
    for (int unsigned k = 0; k < Ratio; k++) begin
      if (CntWidth'(k) <= cnt_q) strb_nxt[k] = 1'b1;
      if (CntWidth'(k) == cnt_q) word_nxt[k*DataWidth +: DataWidth] = in_data_i;
    end
    for (int unsigned k = 0; k < Ratio - 1; k++) begin
      if (CntWidth'(k) < cnt_q) word_nxt[k*DataWidth +: DataWidth] = asm_q[k*DataWidth +: DataWidth];
      if (CntWidth'(k) == cnt_q) asm_nxt[k*DataWidth +: DataWidth] = in_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q       <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
      if (accept) begin
        if (closing) begin
          out_data_q  <= word_nxt;
          out_strb_q  <= strb_nxt;
          out_last_q  <= in_last_i;
          out_valid_q <= 1'b1;
          cnt_q       <= '0;
          asm_q       <= '0;
        end else begin
          asm_q <= asm_nxt;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign out_last_o  = out_last_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_stream_deserializer.sv
// Directed bench: a Ratio=4 instance for word assembly/backpressure/clear and
// a Ratio=1 instance for the single-lane pass-through and async reset.
module tb_stream_deserializer;
  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  logic [7:0]  in_data;
  logic        in_last, in_valid, in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        out_last, out_valid, out_ready;

  logic [7:0]  in_data1;
  logic        in_last1, in_valid1, in_ready1;
  logic [7:0]  out_data1;
  logic [0:0]  out_strb1;
  logic        out_last1, out_valid1, out_ready1;

  int checks = 0;
  int errors = 0;

  stream_deserializer #(.DataWidth(8), .Ratio(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .in_data_i(in_data), .in_last_i(in_last), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_strb_o(out_strb), .out_last_o(out_last),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  stream_deserializer #(.DataWidth(8), .Ratio(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .clr_i(clr),
    .in_data_i(in_data1), .in_last_i(in_last1), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
    .out_data_o(out_data1), .out_strb_o(out_strb1), .out_last_o(out_last1),
    .out_valid_o(out_valid1), .out_ready_i(out_ready1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data1 = '0; in_last1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_strb", {28'd0, out_strb}, 32'h0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_ready_r1", {31'd0, in_ready1}, 32'd1);
    chk("rst_valid_r1", {31'd0, out_valid1}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Full word, one-cycle valid
    beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0);
    chk("full_not_yet", {31'd0, out_valid}, 32'd0);
    beat(8'h44, 1'b0);
    in_valid = 1'b0;
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_data", out_data, 32'h44332211);
    chk("full_strb", {28'd0, out_strb}, 32'hF);
    chk("full_last", {31'd0, out_last}, 32'd0);
    tick();
    chk("full_one_cycle", {31'd0, out_valid}, 32'd0);

    // Early termination on lane 1
    beat(8'hAA, 1'b0); beat(8'hBB, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("early_valid", {31'd0, out_valid}, 32'd1);
    chk("early_data", out_data, 32'h0000BBAA);
    chk("early_strb", {28'd0, out_strb}, 32'h3);
    chk("early_last", {31'd0, out_last}, 32'd1);
    tick();

    // Twelve back-to-back beats -> three words, no stall
    for (int i = 0; i < 12; i++) begin
      in_data = 8'(i + 1); in_last = 1'b0; in_valid = 1'b1;
      #1;
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
      tick();
      if (i % 4 == 3) begin
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_data", out_data, {8'(i + 1), 8'(i), 8'(i - 1), 8'(i - 2)});
      end else begin
        chk("stream_gap", {31'd0, out_valid}, 32'd0);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_idle", {31'd0, out_valid}, 32'd0);

    // Backpressure for 5 cycles, then release together with a closing beat
    out_ready = 1'b0;
    beat(8'hA1, 1'b0); beat(8'hA2, 1'b0); beat(8'hA3, 1'b0); beat(8'hA4, 1'b0);
    in_data = 8'hB1; in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data_stable", out_data, 32'hA4A3A2A1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_data", out_data, 32'h000000B1);
    chk("b2b_strb", {28'd0, out_strb}, 32'h1);
    chk("b2b_last", {31'd0, out_last}, 32'd1);
    tick();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    // Last on the final lane
    beat(8'hC1, 1'b0); beat(8'hC2, 1'b0); beat(8'hC3, 1'b0); beat(8'hC4, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("lastfull_data", out_data, 32'hC4C3C2C1);
    chk("lastfull_strb", {28'd0, out_strb}, 32'hF);
    chk("lastfull_last", {31'd0, out_last}, 32'd1);
    tick();

    // Clear discards a partial word
    beat(8'hE1, 1'b0); beat(8'hE2, 1'b0);
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", {31'd0, out_valid}, 32'd0);
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0);
    chk("clr_no_stale", {31'd0, out_valid}, 32'd0);
    beat(8'h04, 1'b0);
    in_valid = 1'b0;
    chk("clr_word_valid", {31'd0, out_valid}, 32'd1);
    chk("clr_word_data", out_data, 32'h04030201);
    chk("clr_word_strb", {28'd0, out_strb}, 32'hF);
    tick();

    // Ratio=1 pass-through with toggling downstream ready
    in_data1 = 8'h5A; in_valid1 = 1'b1; out_ready1 = 1'b0;
    tick();
    chk("r1_w0_valid", {31'd0, out_valid1}, 32'd1);
    chk("r1_w0_data", {24'd0, out_data1}, 32'h5A);
    chk("r1_w0_strb", {31'd0, out_strb1}, 32'd1);
    in_data1 = 8'hA5;
    #1;
    chk("r1_stall", {31'd0, in_ready1}, 32'd0);
    tick();
    chk("r1_hold_data", {24'd0, out_data1}, 32'h5A);
    out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0; out_ready1 = 1'b0;
    chk("r1_w1_valid", {31'd0, out_valid1}, 32'd1);
    chk("r1_w1_data", {24'd0, out_data1}, 32'hA5);
    chk("r1_w1_last", {31'd0, out_last1}, 32'd0);
    tick();
    chk("r1_w1_hold", {24'd0, out_data1}, 32'hA5);
    out_ready1 = 1'b1;
    tick();
    chk("r1_drained", {31'd0, out_valid1}, 32'd0);

    // Asynchronous reset mid-stream on both instances
    out_ready1 = 1'b0;
    in_data1 = 8'h3C; in_valid1 = 1'b1;
    beat(8'h77, 1'b0);
    in_valid1 = 1'b0;
    beat(8'h88, 1'b0);
    in_valid = 1'b0;
    chk("r1_pre_rst_valid", {31'd0, out_valid1}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid_r1", {31'd0, out_valid1}, 32'd0);
    chk("arst_data_r1", {24'd0, out_data1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick();
    chk("arst_no_spurious", {31'd0, out_valid}, 32'd0);
    chk("arst_no_spurious_r1", {31'd0, out_valid1}, 32'd0);
    out_ready = 1'b1;
    beat(8'h91, 1'b0); beat(8'h92, 1'b0); beat(8'h93, 1'b0); beat(8'h94, 1'b0);
    in_valid = 1'b0;
    chk("arst_fresh_data", out_data, 32'h94939291);
    chk("arst_fresh_strb", {28'd0, out_strb}, 32'hF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_deserializer.md
Name: stream_deserializer

Overview:
- Downstream consumer of the two-phase CDC's destination-side valid/ready stream.
- Gathers Ratio narrow beats into one wide word, so the crossing carries only DataWidth wires while the destination fabric sees full-width words.
- Supports early word termination via a last flag, and a lane strobe that marks which lanes are filled.
- Single clock domain; registered output.

Parameters:
DataWidth, 8, width of one input beat (lane) in bits; >= 1
Ratio, 4, number of lanes per output word; >= 1
CntWidth, (Ratio > 1) ? $clog2(Ratio) : 1, lane counter width; derived, not to be overridden

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous reset, active-high
clr_i  input  1  synchronous clear, active-high
in_data_i  input  DataWidth  input beat
in_last_i  input  1  beat closes the current word, even if lanes remain
in_valid_i  input  1  input beat valid
in_ready_o  output  1  input beat accepted when in_valid_i && in_ready_o
out_data_o  output  DataWidth*Ratio  assembled word; lane k = bits [k*DataWidth +: DataWidth]
out_strb_o  output  Ratio  bit k set = lane k carries data
out_last_o  output  1  word was closed by in_last_i
out_valid_o  output  1  output word valid
out_ready_i  input  1  downstream accepts word

Behaviour:
- Clocking and reset: single clock clk_i; reset rst_i is asynchronous and active-high.
- State:
  - cnt_q: CntWidth-bit lane index of the next beat.
  - asm_q: (Ratio-1)*DataWidth partial-word buffer for lanes 0..Ratio-2.
  - Output registers: out_data_q, out_strb_q, out_last_q, out_valid_q.
- Reset values (rst_i asserted, applied asynchronously): cnt_q=0, asm_q=0, out_data_o=0, out_strb_o=0, out_last_o=0, out_valid_o=0.
- in_ready_o = !out_valid_q || out_ready_i.
  - Combinational path from out_ready_i is intended.
  - in_ready_o does not depend on in_valid_i, in_data_i or in_last_i.
  - During reset, in_ready_o = 1 (out_valid_q=0).
- Lane order: first beat of a word goes to lane 0 (LSBs), then ascending.
- Accepted beat (in_valid_i && in_ready_o):
  - closing = (cnt_q == Ratio-1) || in_last_i.
  - Not closing: write beat to lane cnt_q of asm_q; cnt_q <= cnt_q+1.
  - Closing:
    - out_data_q <= asm_q lanes 0..cnt_q-1, beat in lane cnt_q, lanes above cnt_q zero.
    - out_strb_q <= mask with bits 0..cnt_q set.
    - out_last_q <= in_last_i; out_valid_q <= 1.
    - cnt_q <= 0; asm_q <= 0.
- Output handshake:
  - out_valid_q clears on out_valid_o && out_ready_i, unless a closing beat is accepted in the same cycle; then the new word loads (back-to-back, no bubble).
  - out_data/strb/last hold stable while out_valid_o && !out_ready_i.
- Latency: closing beat accepted in cycle N -> out_valid_o=1 in cycle N+1.
- Throughput: one input beat per cycle while downstream is ready; one word per Ratio cycles for full words.
- Backpressure: while out_valid_o && !out_ready_i, in_ready_o=0. No beat is accepted, including non-closing ones, so there is no partial-word hazard.
- Ratio=1: every accepted beat closes; out_strb_o=1; acts as a one-entry registered stage (cnt_q held at 0).
- in_last_i on lane 0: one-lane word, strb=...0001, out_last_o=1.
- in_last_i on lane Ratio-1: full strb, out_last_o=1.
- clr_i (synchronous, overrides all same-cycle updates):
  - Next state: cnt_q=0, asm_q=0, out_valid_q=0, out regs zeroed.
  - Partial word and pending output are discarded.
  - A beat presented in the clr_i cycle is handshaken (in_ready_o follows its normal rule) but dropped.
- rst_i mid-word: asynchronous return to reset values; partial data lost; no spurious out_valid_o after release.
- No X propagation: out_data_o lanes above the strobe are always zero.

Test Plan:
- Reset release, then 4 beats 0x11,0x22,0x33,0x44 (in_last_i=0 throughout; Ratio=4, DataWidth=8), out_ready_i=1 -> one cycle after 4th beat: out_data_o=0x44332211, out_strb_o=0xF, out_last_o=0, out_valid_o for exactly 1 cycle.
- Beats 0xAA, then 0xBB with in_last_i=1 -> out_data_o=0x0000BBAA, out_strb_o=0x3, out_last_o=1; next word starts at lane 0.
- Continuous input, 12 beats, out_ready_i=1 -> 3 words, no input stall (in_ready_o=1 every cycle), words spaced 4 cycles.
- Word valid with out_ready_i=0 for 5 cycles -> in_ready_o=0, output data stable all 5 cycles; out_ready_i=1 coincident with a new closing beat -> next word follows with no idle cycle.
- 2 beats accepted, then clr_i pulse, then 4 beats 0x01..0x04 -> single word 0x04030201, strb 0xF; no word containing the pre-clear beats.
- Ratio=1, beats 0x5A,0xA5 with out_ready_i toggling -> each beat emitted as its own word, strb=1, order preserved, none lost or duplicated; rst_i asserted mid-stream -> out_valid_o=0 immediately (asynchronously).
